ascii_token_lexer: RTL and testbench
====================================

Name: ascii_token_lexer

Overview:
- Streaming lexer for the seminar calculator datapath. Sits between the ASCII character source and the expression evaluator.
- Accepts one ASCII character per valid/ready handshake. Classifies each character as digit, operator, frame marker (NUL) or error.
- Accumulates multi-digit decimal numbers into a VAL_W-bit value and emits typed tokens on a valid/ready output stream.

Parameters:
- VAL_W, 16: width of the accumulated number value; legal range 4..32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_char is valid.
- in_ready  out  1  lexer accepts in_char this cycle.
- in_char  in  8  ASCII character.
- out_valid  out  1  token is present on the out_* fields.
- out_ready  in  1  downstream consumes the token.
- out_type  out  2  token type: TOK_NUM, TOK_OP, TOK_FRAME or TOK_ERR.
- out_value  out  VAL_W  number value; zero for non-NUM tokens.
- out_op  out  3  operator code; zero unless TOK_OP.
- out_ovf  out  1  NUM token saturated.
- out_char  out  8  raw character for OP, FRAME and ERR tokens; zero for NUM.
- busy  out  1  number accumulation in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high and after it falls: out_valid=0, pending slot empty, accumulator=0, acc_active=0, ovf flag=0, all out_* fields=0, busy=0.
- Classification (combinational):
  - Digits are 0x30..0x39.
  - Operators: '*'(0x2A)=OP_MUL 0, '+'(0x2B)=OP_ADD 1, '/'(0x2F)=OP_DIV 2, '<'(0x3C)=OP_LT 3, '='(0x3D)=OP_EQ 4, '>'(0x3E)=OP_GT 5.
  - 0x00 is FRAME.
  - Every other value is ERR.
- Storage: one output register plus one pending token slot.
- in_ready = !pend_valid && (!out_valid || out_ready). This is combinational and never depends on in_valid.
- Digit accepted:
  - acc_next = acc*10 + digit, computed at VAL_W+4 bits.
  - If acc_next > 2^VAL_W-1 or the ovf flag is already set: acc = all-ones and ovf flag = 1. Otherwise acc = acc_next.
  - acc_active=1. No token is produced.
  - busy = acc_active.
- Non-digit accepted with acc_active=0: the char token loads the output register. out_valid=1 on the next cycle (latency 1).
- Non-digit accepted with acc_active=1:
  - The output register loads a NUM token: value=acc, out_ovf=ovf flag.
  - The pending slot loads the char token.
  - acc, acc_active and the ovf flag clear.
  - in_ready drops until the pending token moves to the output register.
- Output register update:
  - If out_valid && out_ready and the pending slot is valid, the pending token moves into the output register on that edge (back-to-back, no bubble).
  - If out_valid && out_ready, the pending slot is empty and a new token is produced in the same cycle, the new token loads (throughput 1 token/cycle).
- FRAME token: terminates any number in progress, as above. It additionally marks the expression boundary; downstream uses it as start/stop.
- ERR token: carries the raw char in out_char. It terminates a number the same way as an operator.
- Output stability: the out_* fields hold stable while out_valid && !out_ready.
- Reset mid-operation: a partial number is discarded and no NUM token is produced. A token held in the output register or pending slot is dropped.
- Simultaneous events:
  - Accept and emit in the same cycle is legal.
  - in_valid with in_ready=0 performs no state change; the source holds its char.

Optional Feature:
- Macro: LEXER_SPACE_SKIP_EN.
- Defined:
  - Space (0x20), TAB (0x09), CR (0x0D) and LF (0x0A) are accepted and produce no token.
  - If acc_active, a whitespace char terminates the number. A NUM token is emitted with the pending slot left empty. "12 34" yields NUM 12, then NUM 34.
- Undefined: these characters are ERR tokens.

Decomposition:
- Package ascii_lex_pkg holds:
  - the token type enum: TOK_NUM=0, TOK_OP=1, TOK_FRAME=2, TOK_ERR=3;
  - the op code constants OP_MUL..OP_GT;
  - ASCII constants CH_NUL, CH_0, CH_9, CH_SPACE;
  - a packed token struct {type, value, op, ovf, char}.
- Sub-module ascii_char_classifier: purely combinational.
  - Input: 8-bit char.
  - Outputs: is_digit, digit_val[3:0], is_op, op_code[2:0], is_frame, is_space.
  - The lexer instantiates it once on in_char.

Test Plan:
- Stream "12+3\0" with out_ready=1 -> NUM 12, OP 1 ('+'), NUM 3, FRAME, in that order; in_ready low for exactly 1 cycle after '+' and 1 cycle after NUL.
- Stream '7','*' with out_ready held 0 for 5 cycles after '*' -> NUM 7 stable for 5 cycles, in_ready=0 throughout; OP 0 appears the cycle after the NUM handshake completes.
- VAL_W=8, stream "300=" -> NUM 255 with out_ovf=1, then OP 4; a following "25=" -> NUM 25 with out_ovf=0.
- Stream 'A' (0x41) with no number in progress -> ERR token, out_char=0x41, latency 1 cycle; stream "9A" -> NUM 9, then ERR 0x41.
- Stream "45" then assert rst for 1 cycle, then "=" -> only OP 4 is emitted; all outputs are 0 during rst.
- LEXER_SPACE_SKIP_EN defined: stream "1 2\n" -> NUM 1, NUM 2, no other tokens; undefined: the same stream -> NUM 1, ERR 0x20, NUM 2, ERR 0x0A.

Source files
------------

// File: rtl/ascii_lex_pkg.sv
// Shared types and constants for the ASCII token lexer.
package ascii_lex_pkg;

  localparam int unsigned VAL_MAX_W = 32;

  typedef enum logic [1:0] {
    TOK_NUM   = 2'd0,
    TOK_OP    = 2'd1,
    TOK_FRAME = 2'd2,
    TOK_ERR   = 2'd3
  } tok_type_t;

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_DIV = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;
  localparam logic [2:0] OP_GT  = 3'd5;

  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  // value is sized for the widest legal VAL_W; narrower lexers zero-extend
  typedef struct packed {
    tok_type_t              typ;
    logic [VAL_MAX_W-1:0]   value;
    logic [2:0]             op;
    logic                   ovf;
    logic [7:0]             ch;
  } token_t;

  function automatic token_t char_token(input tok_type_t typ, input logic [2:0] op,
                                        input logic [7:0] ch);
    token_t t;
    t       = '0;
    t.typ   = typ;
    t.op    = op;
    t.ch    = ch;
    return t;
  endfunction

endpackage

// File: rtl/ascii_lex_char_classifier.sv
// Combinational ASCII character classifier for the lexer.
// Whitespace detection is only present when LEXER_SPACE_SKIP_EN is defined.
module ascii_char_classifier
  import ascii_lex_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] digit_val,
  output logic       is_op,
  output logic [2:0] op_code,
  output logic       is_frame,
  output logic       is_space
);

  always_comb begin
    is_digit  = (ch >= CH_0) && (ch <= CH_9);
    digit_val = is_digit ? ch[3:0] : 4'd0;
    is_frame  = (ch == CH_NUL);
    is_op     = 1'b1;
    op_code   = 3'd0;
    case (ch)
      8'h2A:   op_code = OP_MUL;
      8'h2B:   op_code = OP_ADD;
      8'h2F:   op_code = OP_DIV;
      8'h3C:   op_code = OP_LT;
      8'h3D:   op_code = OP_EQ;
      8'h3E:   op_code = OP_GT;
      default: is_op   = 1'b0;
    endcase
`ifdef LEXER_SPACE_SKIP_EN
    is_space = (ch == CH_SPACE) || (ch == CH_TAB) || (ch == CH_CR) || (ch == CH_LF);
`else
    is_space = 1'b0;
`endif
  end

endmodule

// File: rtl/ascii_token_lexer.sv
// Streaming ASCII lexer: digits accumulate into NUM tokens, other chars become OP/FRAME/ERR.
// Define LEXER_SPACE_SKIP_EN to treat whitespace as a silent number separator.
module ascii_token_lexer
  import ascii_lex_pkg::*;
#(
  parameter int unsigned VAL_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_type,
  output logic [VAL_W-1:0] out_value,
  output logic [2:0]       out_op,
  output logic             out_ovf,
  output logic [7:0]       out_char,
  output logic             busy
);

  localparam int unsigned EXT_W = VAL_W + 4;

  logic             is_digit, is_op, is_frame, is_space;
  logic [3:0]       digit_val;
  logic [2:0]       op_code;

  logic [VAL_W-1:0] acc_q, acc_d;
  logic             act_q, act_d;
  logic             ovf_q, ovf_d;
  token_t           out_q, out_d;
  logic             out_vld_q, out_vld_d;
  token_t           pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;

  logic [EXT_W-1:0] acc_ext, acc_mul;
  logic             sat;
  logic             accept, fire;
  token_t           num_tok, chr_tok;
  tok_type_t        chr_type;

  ascii_char_classifier u_class (
    .ch        (in_char),
    .is_digit  (is_digit),
    .digit_val (digit_val),
    .is_op     (is_op),
    .op_code   (op_code),
    .is_frame  (is_frame),
    .is_space  (is_space)
  );

  assign in_ready = !pend_vld_q && (!out_vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = out_vld_q && out_ready;

  // Decimal accumulate with sticky saturation
  always_comb begin
    acc_ext = EXT_W'(acc_q);
    acc_mul = (acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit_val);
    sat     = ovf_q || (|acc_mul[EXT_W-1:VAL_W]);
  end

  always_comb begin
    chr_type = is_frame ? TOK_FRAME : (is_op ? TOK_OP : TOK_ERR);
    chr_tok  = char_token(chr_type, is_op ? op_code : 3'd0, in_char);
    num_tok       = '0;
    num_tok.typ   = TOK_NUM;
    num_tok.value = VAL_MAX_W'(acc_q);
    num_tok.ovf   = ovf_q;
  end

  // Next-state: pending token drains first, otherwise accepted chars may produce tokens
  always_comb begin
    acc_d      = acc_q;
    act_d      = act_q;
    ovf_d      = ovf_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (fire) out_vld_d = 1'b0;

    if (fire && pend_vld_q) begin
      out_d      = pend_q;
      out_vld_d  = 1'b1;
      pend_vld_d = 1'b0;
    end else if (accept) begin
      if (is_digit) begin
        acc_d = sat ? '1 : acc_mul[VAL_W-1:0];
        ovf_d = sat;
        act_d = 1'b1;
      end else if (is_space) begin
        if (act_q) begin
          out_d     = num_tok;
          out_vld_d = 1'b1;
          acc_d     = '0;
          act_d     = 1'b0;
          ovf_d     = 1'b0;
        end
      end else if (act_q) begin
        out_d      = num_tok;
        out_vld_d  = 1'b1;
        pend_d     = chr_tok;
        pend_vld_d = 1'b1;
        acc_d      = '0;
        act_d      = 1'b0;
        ovf_d      = 1'b0;
      end else begin
        out_d     = chr_tok;
        out_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      act_q      <= 1'b0;
      ovf_q      <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      act_q      <= act_d;
      ovf_q      <= ovf_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_type  = out_q.typ;
  assign out_value = out_q.value[VAL_W-1:0];
  assign out_op    = out_q.op;
  assign out_ovf   = out_q.ovf;
  assign out_char  = out_q.ch;
  assign busy      = act_q;

  if (VAL_W < VAL_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |out_q.value[VAL_MAX_W-1:VAL_W];
  end

endmodule

// File: tb/tb_ascii_token_lexer.sv
// Scoreboard bench for ascii_token_lexer (VAL_W=8); expectations follow LEXER_SPACE_SKIP_EN.
module tb_ascii_token_lexer;

  localparam int unsigned VAL_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_type;
  logic [VAL_W-1:0] out_value;
  logic [2:0]       out_op;
  logic             out_ovf;
  logic [7:0]       out_char;
  logic             busy;

  typedef struct packed {
    logic [1:0]       t;
    logic [VAL_W-1:0] v;
    logic [2:0]       op;
    logic             ovf;
    logic [7:0]       ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ascii_token_lexer #(.VAL_W(VAL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_value (out_value),
    .out_op    (out_op),
    .out_ovf   (out_ovf),
    .out_char  (out_char),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic exp_num(input int v, input logic ovf);
    exp_t e;
    e = '0; e.t = 2'd0; e.v = VAL_W'(v); e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic exp_chr(input logic [1:0] t, input logic [2:0] op, input logic [7:0] ch);
    exp_t e;
    e = '0; e.t = t; e.op = op; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_char  = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 for char 0x%0h", c);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 32'(out_valid), 0);
    check({name, "_fields"}, 32'({out_type, out_value, out_op, out_ovf, out_char}), 0);
    check({name, "_busy"}, 32'(busy), 0);
  endtask

  // Monitor: pop and compare on every output handshake
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
        a = {out_type, out_value, out_op, out_ovf, out_char};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_token: got type=%0d val=%0d op=%0d ovf=%0d ch=0x%0h",
                   out_type, out_value, out_op, out_ovf, out_char);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL token: got type=%0d val=%0d op=%0d ovf=%0d ch=0x%0h, expected type=%0d val=%0d op=%0d ovf=%0d ch=0x%0h",
                     out_type, out_value, out_op, out_ovf, out_char, e.t, e.v, e.op, e.ovf, e.ch);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    #1;
    check_idle_outputs("reset_async");
    repeat (2) tick();
    rst = 1'b0;
    check_idle_outputs("after_reset");
    check("in_ready_idle", 32'(in_ready), 1);

    // "12+3\0": NUM 12, OP +, NUM 3, FRAME; one-cycle in_ready drop after '+' and NUL
    exp_num(12, 0); exp_chr(2'd1, 3'd1, 8'h2B); exp_num(3, 0); exp_chr(2'd2, 3'd0, 8'h00);
    send("1");
    check("busy_digit", 32'(busy), 1);
    send("2"); send("+");
    check("rdy_after_plus_0", 32'(in_ready), 0);
    tick();
    check("rdy_after_plus_1", 32'(in_ready), 1);
    send("3"); send(8'h00);
    check("rdy_after_nul_0", 32'(in_ready), 0);
    tick();
    check("rdy_after_nul_1", 32'(in_ready), 1);
    tick();

    // Backpressure: NUM 7 held stable for 5 cycles, OP * follows the handshake
    exp_num(7, 0); exp_chr(2'd1, 3'd0, 8'h2A);
    send("7");
    out_ready = 1'b0;
    send("*");
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_value", 32'({out_type, out_value, out_ovf}), 32'({2'd0, 8'd7, 1'b0}));
      check("stall_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("op_after_stall", 32'({out_valid, out_type, out_op}), 32'({1'b1, 2'd1, 3'd0}));
    tick();

    // Saturation boundaries at 8 bits
    exp_num(255, 1); exp_chr(2'd1, 3'd4, 8'h3D);
    send_str("300=");
    exp_num(25, 0); exp_chr(2'd1, 3'd4, 8'h3D);
    send_str("25=");
    exp_num(255, 0); exp_chr(2'd1, 3'd3, 8'h3C);
    send_str("255<");
    exp_num(255, 1); exp_chr(2'd1, 3'd5, 8'h3E);
    send_str("256>");
    exp_num(0, 0); exp_chr(2'd1, 3'd2, 8'h2F);
    send_str("0/");
    tick(); tick();

    // ERR with no number: latency 1; then "9A"
    exp_chr(2'd3, 3'd0, 8'h41);
    out_ready = 1'b0;
    send("A");
    check("err_latency", 32'({out_valid, out_type, out_char}), 32'({1'b1, 2'd3, 8'h41}));
    out_ready = 1'b1;
    exp_num(9, 0); exp_chr(2'd3, 3'd0, 8'h41);
    send_str("9A");
    tick(); tick();

    // Reset mid-number discards the partial value
    send_str("45");
    check("busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    tick();
    rst = 1'b0;
    check_idle_outputs("post_mid_reset");
    exp_chr(2'd1, 3'd4, 8'h3D);
    send("=");
    tick(); tick();

    // Whitespace handling depends on the build option
`ifdef LEXER_SPACE_SKIP_EN
    exp_num(1, 0); exp_num(2, 0);
`else
    exp_num(1, 0); exp_chr(2'd3, 3'd0, 8'h20); exp_num(2, 0); exp_chr(2'd3, 3'd0, 8'h0A);
`endif
    send_str("1 2");
    send(8'h0A);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 0);
    check("final_valid", 32'(out_valid), 0);
    check("final_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
